ifft8_serial: RTL and testbench



---
 rtl/ifft8_serial.sv | 237 +++++++++++++++++++++++
 tb/tb_ifft8_serial.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft8_serial.sv
// Serial 8-point radix-2 inverse FFT: bins are loaded in bit-reversed order, transformed
// in place one butterfly per cycle, then streamed out in natural order scaled by 1/8.
//
// state     | meaning
// S_LOAD    | accepting 8 frequency bins
// S_COMPUTE | 12 butterflies, then one transition cycle
// S_OUTPUT  | presenting x[0..7] to the sink
module ifft8_serial #(
  parameter int DATA_W = 32,
  parameter int TW_Q   = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [2:0]               out_idx,
  output logic                     out_last,
  output logic                     busy
);

  localparam int IW = DATA_W + 4;
  localparam int PW = IW + TW_Q + 3;

  function automatic logic [63:0] isqrt_round(input logic [63:0] n);
    logic [63:0] r;
    logic [63:0] cand;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      cand = r | (64'd1 << i);
      if (cand * cand <= n) r = cand;
    end
    if (n - r * r > r) r = r + 64'd1;
    return r;
  endfunction

  // round(2^TW_Q / sqrt(2)) == round(sqrt(2^(2*TW_Q-1)))
  localparam logic [63:0]          C_FULL = isqrt_round(64'd1 << (2 * TW_Q - 1));
  localparam logic signed [PW-1:0] C_TW   = PW'(C_FULL);

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic logic signed [IW-1:0] cmul(input logic signed [IW:0] v);
    logic signed [PW-1:0] pv;
    logic signed [PW-1:0] p;
    pv = PW'(v);
    p  = pv * C_TW;
    return p[IW+TW_Q-1:TW_Q];
  endfunction

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_in_ready;
  logic       r_out_valid;
  logic       r_busy;
  logic       w_load_en;
  logic       w_bfly_en;

  logic signed [IW-1:0] r_buf_re [0:7];
  logic signed [IW-1:0] r_buf_im [0:7];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_en   = 1'b0;
    w_bfly_en   = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (in_valid && r_in_ready) begin
          w_load_en = 1'b1;
          if (r_cnt == 4'd7) begin
            w_state_nxt = S_COMPUTE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      S_COMPUTE: begin
        // count 12 is the idle transition cycle before output starts
        if (r_cnt == 4'd12) begin
          w_state_nxt = S_OUTPUT;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_bfly_en = 1'b1;
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_OUTPUT: begin
        if (r_out_valid && out_ready) begin
          if (r_cnt == 4'd7) begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= 4'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == S_LOAD);
      r_out_valid <= (w_state_nxt == S_OUTPUT);
      r_busy      <= (w_state_nxt != S_LOAD);
    end
  end

  logic [1:0] w_stage;
  logic [1:0] w_j;
  logic [2:0] w_top;
  logic [2:0] w_bot;
  logic [1:0] w_m;

  assign w_stage = r_cnt[3:2];
  assign w_j     = r_cnt[1:0];

  // Pairs in ascending top-address order; m is the inverse-twiddle exponent.
  always_comb begin
    w_top = 3'd0;
    w_bot = 3'd0;
    w_m   = 2'd0;
    case (w_stage)
      2'd0: begin
        w_top = {w_j, 1'b0};
        w_bot = {w_j, 1'b1};
        w_m   = 2'd0;
      end
      2'd1: begin
        w_top = {w_j[1], 1'b0, w_j[0]};
        w_bot = {w_j[1], 1'b1, w_j[0]};
        w_m   = {w_j[0], 1'b0};
      end
      default: begin
        w_top = {1'b0, w_j};
        w_bot = {1'b1, w_j};
        w_m   = w_j;
      end
    endcase
  end

  logic signed [IW-1:0] w_a_re;
  logic signed [IW-1:0] w_a_im;
  logic signed [IW-1:0] w_b_re;
  logic signed [IW-1:0] w_b_im;
  logic signed [IW:0]   w_v_diff;
  logic signed [IW:0]   w_v_sum;
  logic signed [IW:0]   w_v_neg;
  logic signed [IW-1:0] w_t_re;
  logic signed [IW-1:0] w_t_im;

  assign w_a_re   = r_buf_re[w_top];
  assign w_a_im   = r_buf_im[w_top];
  assign w_b_re   = r_buf_re[w_bot];
  assign w_b_im   = r_buf_im[w_bot];
  assign w_v_diff = {w_b_re[IW-1], w_b_re} - {w_b_im[IW-1], w_b_im};
  assign w_v_sum  = {w_b_re[IW-1], w_b_re} + {w_b_im[IW-1], w_b_im};
  assign w_v_neg  = -{w_b_re[IW-1], w_b_re} - {w_b_im[IW-1], w_b_im};

  always_comb begin
    w_t_re = w_b_re;
    w_t_im = w_b_im;
    case (w_m)
      2'd0: begin
        w_t_re = w_b_re;
        w_t_im = w_b_im;
      end
      2'd1: begin
        w_t_re = cmul(w_v_diff);
        w_t_im = cmul(w_v_sum);
      end
      2'd2: begin
        w_t_re = -w_b_im;
        w_t_im = w_b_re;
      end
      default: begin
        w_t_re = cmul(w_v_neg);
        w_t_im = cmul(w_v_diff);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load_en) begin
      r_buf_re[bitrev3(r_cnt[2:0])] <= {{4{in_re[DATA_W-1]}}, in_re};
      r_buf_im[bitrev3(r_cnt[2:0])] <= {{4{in_im[DATA_W-1]}}, in_im};
    end else if (w_bfly_en) begin
      r_buf_re[w_top] <= w_a_re + w_t_re;
      r_buf_im[w_top] <= w_a_im + w_t_im;
      r_buf_re[w_bot] <= w_a_re - w_t_re;
      r_buf_im[w_bot] <= w_a_im - w_t_im;
    end
  end

  logic signed [IW-1:0] w_out_re_full;
  logic signed [IW-1:0] w_out_im_full;

  assign w_out_re_full = r_buf_re[r_cnt[2:0]] >>> 3;
  assign w_out_im_full = r_buf_im[r_cnt[2:0]] >>> 3;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_re    = r_out_valid ? w_out_re_full[DATA_W-1:0] : '0;
  assign out_im    = r_out_valid ? w_out_im_full[DATA_W-1:0] : '0;
  assign out_idx   = r_out_valid ? r_cnt[2:0] : 3'd0;
  assign out_last  = r_out_valid && (r_cnt == 4'd7);

endmodule

// File: tb/tb_ifft8_serial.sv
// Bench for ifft8_serial: directed spectra with known time-domain results plus random
// frames under backpressure and mid-frame resets, checked against an array-based IFFT model.
module tb_ifft8_serial;

  localparam int     DATA_W = 32;
  localparam int     TWQ    = 15;
  localparam longint CTW    = 23170;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [DATA_W-1:0] in_re = '0;
  logic signed [DATA_W-1:0] in_im = '0;
  logic signed [DATA_W-1:0] out_re, out_im;
  logic [2:0] out_idx;

  ifft8_serial #(.DATA_W(DATA_W), .TW_Q(TWQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  longint fr[8], fi[8], er[8], ei[8], gr[8], gi[8];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint cfl(input longint v);
    return (v * CTW) >>> TWQ;
  endfunction

  // Textbook in-place decimation-in-time IFFT over bit-reversed input, using e^{+j*2*pi*m/8}.
  task automatic model();
    longint br[8], bi[8];
    longint tr, ti;
    for (int k = 0; k < 8; k++) begin
      int rk;
      rk = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      br[rk] = fr[k];
      bi[rk] = fi[k];
    end
    for (int s = 0; s < 3; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int i = 0; i < h; i++) begin
          int p, q, m;
          p = g + i;
          q = p + h;
          m = i * (4 >> s);
          case (m)
            0: begin tr = br[q]; ti = bi[q]; end
            1: begin tr = cfl(br[q] - bi[q]); ti = cfl(br[q] + bi[q]); end
            2: begin tr = -bi[q]; ti = br[q]; end
            default: begin tr = cfl(-br[q] - bi[q]); ti = cfl(br[q] - bi[q]); end
          endcase
          br[q] = br[p] - tr;
          bi[q] = bi[p] - ti;
          br[p] = br[p] + tr;
          bi[p] = bi[p] + ti;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      er[n] = longint'(int'(br[n] >>> 3));
      ei[n] = longint'(int'(bi[n] >>> 3));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_high", in_ready, 1);
  endtask

  // abort_mode: 0 full frame, 1 return in compute cycle 5, 2 return once idx 3 is accepted
  task automatic run_frame(input int pin, input int pout, input int abort_mode);
    int k, n, t, acc_cyc, pidx;
    bit stall, seen;
    longint pr, pim;
    model();
    k = 0;
    t = 0;
    while (k < 8 && t < 400) begin
      @(negedge clk);
      t++;
      chk("load_busy", busy, 0);
      chk("load_out_valid", out_valid, 0);
      in_valid = ($urandom_range(99) < pin);
      if (in_valid) begin
        in_re = fr[k][DATA_W-1:0];
        in_im = fi[k][DATA_W-1:0];
      end else begin
        in_re = $urandom;
        in_im = $urandom;
      end
      if (in_valid && in_ready) k++;
    end
    chk("load_accepts", k, 8);
    if (k < 8) return;
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b1;
    in_re = $urandom;
    in_im = $urandom;
    chk("ready_drop", in_ready, 0);
    chk("busy_compute", busy, 1);
    if (abort_mode == 1) begin
      repeat (4) @(negedge clk);
      return;
    end
    n = 0;
    t = 0;
    seen = 0;
    stall = 0;
    pr = 0;
    pim = 0;
    pidx = 0;
    while (n < 8 && t < 400) begin
      @(negedge clk);
      t++;
      in_valid = $urandom_range(1);
      in_re = $urandom;
      in_im = $urandom;
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          chk("latency", cyc - acc_cyc, 13);
        end
        if (stall) begin
          chk("hold_re", out_re, pr);
          chk("hold_im", out_im, pim);
          chk("hold_idx", out_idx, pidx);
        end
        chk("out_idx", out_idx, n);
        chk("out_re", out_re, er[n]);
        chk("out_im", out_im, ei[n]);
        chk("out_last", out_last, (n == 7) ? 1 : 0);
        chk("busy_output", busy, 1);
        chk("in_ready_output", in_ready, 0);
        gr[n] = out_re;
        gi[n] = out_im;
        pr = out_re;
        pim = out_im;
        pidx = out_idx;
        out_ready = ($urandom_range(99) < pout);
        stall = !out_ready;
        if (out_ready) begin
          n++;
          if (abort_mode == 2 && n == 4) return;
        end
      end else begin
        out_ready = $urandom_range(1);
        stall = 0;
      end
    end
    chk("out_count", n, 8);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("end_valid_drop", out_valid, 0);
    chk("end_in_ready", in_ready, 1);
    chk("end_busy", busy, 0);
  endtask

  task automatic clear_bins();
    for (int k = 0; k < 8; k++) begin
      fr[k] = 0;
      fi[k] = 0;
    end
  endtask

  task automatic random_bins();
    for (int k = 0; k < 8; k++) begin
      fr[k] = longint'(int'($urandom));
      fi[k] = longint'(int'($urandom));
    end
  endtask

  initial begin
    longint jr[4], ji[4];
    jr[0] = 1000; jr[1] = 0;    jr[2] = -1000; jr[3] = 0;
    ji[0] = 0;    ji[1] = 1000; ji[2] = 0;     ji[3] = -1000;

    #3;
    do_reset();

    // impulse at DC
    clear_bins();
    fr[0] = 8;
    run_frame(100, 100, 0);
    for (int n = 0; n < 8; n++) begin
      chk("impulse_re", gr[n], 1);
      chk("impulse_im", gi[n], 0);
    end

    // constant spectrum
    for (int k = 0; k < 8; k++) begin
      fr[k] = 8;
      fi[k] = 0;
    end
    run_frame(100, 100, 0);
    for (int n = 0; n < 8; n++) begin
      chk("const_re", gr[n], (n == 0) ? 8 : 0);
      chk("const_im", gi[n], 0);
    end

    // bin 2 -> 1000*j^n
    clear_bins();
    fr[2] = 8000;
    run_frame(100, 100, 0);
    for (int n = 0; n < 8; n++) begin
      chk("bin2_re", gr[n], jr[n % 4]);
      chk("bin2_im", gi[n], ji[n % 4]);
    end

    // bin 1 -> exercises the 1/sqrt(2) twiddles
    clear_bins();
    fr[1] = 8000;
    run_frame(100, 100, 0);
    chk("bin1_x0_re", gr[0], 1000);
    chk("bin1_x1_re", gr[1], 707);
    chk("bin1_x1_im", gi[1], 707);
    chk("bin1_x2_im", gi[2], 1000);
    chk("bin1_x4_re", gr[4], -1000);
    chk("bin1_x6_im", gi[6], -1000);

    // random frames with backpressure on both sides
    for (int f = 0; f < 6; f++) begin
      random_bins();
      run_frame(60, 50, 0);
    end

    // reset during compute, then a clean frame
    random_bins();
    run_frame(100, 100, 1);
    do_reset();
    random_bins();
    run_frame(70, 60, 0);

    // reset during output after idx 3, then a clean frame
    random_bins();
    run_frame(80, 100, 2);
    @(posedge clk);
    #2;
    do_reset();
    random_bins();
    run_frame(100, 40, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
